group_id_map_pipe: RTL and testbench

- Parametrised, registered successor of the fixed 4-port group-ID mapper in the ATS multi-queue ingress path.
- Takes a descriptor (one-hot dst port, one-hot src port, priority, opaque tag) and emits the shaper group ID.
- Group ID = src rank (source index with the destination removed) × NUM_PRI + pri.
- Adds a valid/ready handshake, one register stage, malformed-descriptor detection with drop/flag mode, and a saturating drop counter.

---
 rtl/gid_map_pkg.sv | 29 ++
 rtl/gid_map_decode.sv | 35 +++
 rtl/group_id_map_pipe.sv | 93 +++++++++
 tb/tb_group_id_map_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gid_map_pkg.sv
// Shared group-ID helpers: one-hot decode and width computation, also used by
// the shaper queue-select logic.
`timescale 1ns/1ps
package gid_map_pkg;

  localparam int MAX_PORTS = 32;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int gid_width(input int ports, input int pri);
    return clog2_min1((ports - 1) * pri);
  endfunction

  // Highest set bit wins; only meaningful when the vector is one-hot.
  function automatic int onehot_idx(input logic [MAX_PORTS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++)
      if (v[i]) idx = i;
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_PORTS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/gid_map_decode.sv
// Combinational descriptor decode: source rank with the destination removed,
// scaled by priority count, plus malformed-descriptor detection.
`timescale 1ns/1ps
module gid_map_decode
  import gid_map_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int NUM_PRI   = 4,
  parameter int PRI_W     = clog2_min1(NUM_PRI),
  parameter int GID_W     = gid_width(NUM_PORTS, NUM_PRI)
) (
  input  logic [NUM_PORTS-1:0] dst,
  input  logic [NUM_PORTS-1:0] src,
  input  logic [PRI_W-1:0]     pri,
  output logic [GID_W-1:0]     gid,
  output logic                 err
);

  localparam bit PRI_POW2 = (NUM_PRI & (NUM_PRI - 1)) == 0;

  int s_idx;
  int d_idx;
  int rank;

  always_comb begin
    s_idx = onehot_idx(MAX_PORTS'(src));
    d_idx = onehot_idx(MAX_PORTS'(dst));
    rank  = (s_idx > d_idx) ? s_idx - 1 : s_idx;
    gid   = GID_W'(rank * NUM_PRI + int'(pri));
    err   = !is_onehot(MAX_PORTS'(src)) || !is_onehot(MAX_PORTS'(dst)) || (src == dst);
    // Out-of-range priority codes only exist when NUM_PRI leaves spare encodings.
    if (!PRI_POW2) err = err || (int'(pri) >= NUM_PRI);
  end

endmodule

// File: rtl/group_id_map_pipe.sv
// Registered group-ID mapper with valid/ready handshake, malformed-descriptor
// drop/flag handling and a saturating drop counter.
`timescale 1ns/1ps
module group_id_map_pipe
  import gid_map_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int NUM_PRI      = 4,
  parameter int PRI_W        = clog2_min1(NUM_PRI),
  parameter int GID_W        = gid_width(NUM_PORTS, NUM_PRI),
  parameter int TAG_W        = 16,
  parameter bit DROP_INVALID = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_PORTS-1:0] in_dst,
  input  logic [NUM_PORTS-1:0] in_src,
  input  logic [PRI_W-1:0]     in_pri,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [GID_W-1:0]     out_gid,
  output logic                 out_err,
  output logic [TAG_W-1:0]     out_tag,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     drop_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [GID_W-1:0] gid_p0;
  logic             err_p0;
  logic             accept_p0;
  logic             drop_p0;

  logic             vld_p1;
  logic [GID_W-1:0] gid_p1;
  logic             err_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [CNT_W-1:0] cnt_p1;

  gid_map_decode #(
    .NUM_PORTS (NUM_PORTS),
    .NUM_PRI   (NUM_PRI),
    .PRI_W     (PRI_W),
    .GID_W     (GID_W)
  ) u_decode (
    .dst (in_dst),
    .src (in_src),
    .pri (in_pri),
    .gid (gid_p0),
    .err (err_p0)
  );

  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign drop_p0   = accept_p0 && err_p0 && DROP_INVALID;

  // Stage p0 -> p1: output register. A drop only retires a consumed beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      gid_p1 <= '0;
      err_p1 <= 1'b0;
      tag_p1 <= '0;
    end else if (accept_p0 && !drop_p0) begin
      vld_p1 <= 1'b1;
      gid_p1 <= err_p0 ? '0 : gid_p0;
      err_p1 <= err_p0;
      tag_p1 <= in_tag;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           cnt_p1 <= '0;
    else if (stat_clr) cnt_p1 <= '0;
    else if (drop_p0)  cnt_p1 <= sat_inc(cnt_p1);
  end

  assign out_valid = vld_p1;
  assign out_gid   = gid_p1;
  assign out_err   = err_p1;
  assign out_tag   = tag_p1;
  assign drop_cnt  = cnt_p1;

endmodule

// File: tb/tb_group_id_map_pipe.sv
// Scoreboard bench for group_id_map_pipe: default drop mode, flag mode and an
// 8-port / 8-priority / 2-bit counter build.
`timescale 1ns/1ps
module tb_group_id_map_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // A: defaults (drop mode)
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_ordy = 1, a_out_err, a_clr = 0;
  logic [3:0] a_dst = 0, a_src = 0;
  logic [1:0] a_pri = 0;
  logic [15:0] a_tag = 0, a_out_tag, a_cnt;
  logic [3:0] a_out_gid;
  // B: flag mode
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_ordy = 1, b_out_err, b_clr = 0;
  logic [3:0] b_dst = 0, b_src = 0;
  logic [1:0] b_pri = 0;
  logic [15:0] b_tag = 0, b_out_tag, b_cnt;
  logic [3:0] b_out_gid;
  // C: 8 ports, 8 priorities, 2-bit counter
  logic c_in_valid = 0, c_in_ready, c_out_valid, c_ordy = 1, c_out_err, c_clr = 0;
  logic [7:0] c_dst = 0, c_src = 0;
  logic [2:0] c_pri = 0;
  logic [15:0] c_tag = 0, c_out_tag;
  logic [1:0] c_cnt;
  logic [5:0] c_out_gid;

  group_id_map_pipe u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_dst(a_dst), .in_src(a_src), .in_pri(a_pri), .in_tag(a_tag),
    .out_valid(a_out_valid), .out_ready(a_ordy), .out_gid(a_out_gid),
    .out_err(a_out_err), .out_tag(a_out_tag), .stat_clr(a_clr), .drop_cnt(a_cnt));

  group_id_map_pipe #(.DROP_INVALID(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_dst(b_dst), .in_src(b_src), .in_pri(b_pri), .in_tag(b_tag),
    .out_valid(b_out_valid), .out_ready(b_ordy), .out_gid(b_out_gid),
    .out_err(b_out_err), .out_tag(b_out_tag), .stat_clr(b_clr), .drop_cnt(b_cnt));

  group_id_map_pipe #(.NUM_PORTS(8), .NUM_PRI(8), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_dst(c_dst), .in_src(c_src), .in_pri(c_pri), .in_tag(c_tag),
    .out_valid(c_out_valid), .out_ready(c_ordy), .out_gid(c_out_gid),
    .out_err(c_out_err), .out_tag(c_out_tag), .stat_clr(c_clr), .drop_cnt(c_cnt));

  // Expected beat packed as {err, gid[7:0], tag[15:0]}
  logic [24:0] qa[$], qb[$], qc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, inout logic [24:0] q[$], input logic [24:0] act);
    if (q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: unexpected beat %0h, expected none", name, act);
    end else begin
      check(name, 32'(act), 32'(q.pop_front()));
    end
  endtask

  // Monitors: a beat retires on valid && ready, sampled mid-cycle
  always @(negedge clk)
    if (!rst && a_out_valid && a_ordy) pop_cmp("a_beat", qa, {a_out_err, 4'h0, a_out_gid, a_out_tag});
  always @(negedge clk)
    if (!rst && b_out_valid && b_ordy) pop_cmp("b_beat", qb, {b_out_err, 4'h0, b_out_gid, b_out_tag});
  always @(negedge clk)
    if (!rst && c_out_valid && c_ordy) pop_cmp("c_beat", qc, {c_out_err, 2'h0, c_out_gid, c_out_tag});

  task automatic send_a(input logic [3:0] dst, input logic [3:0] src, input logic [1:0] pri,
                        input logic [15:0] tag, input bit expout, input logic [7:0] gid, input bit err);
    int n;
    a_in_valid = 1; a_dst = dst; a_src = src; a_pri = pri; a_tag = tag;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!a_in_ready) check("a_ready_timeout", 0, 1);
    else if (expout) qa.push_back({err, gid, tag});
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [3:0] dst, input logic [3:0] src, input logic [1:0] pri,
                        input logic [15:0] tag, input bit expout, input logic [7:0] gid, input bit err);
    int n;
    b_in_valid = 1; b_dst = dst; b_src = src; b_pri = pri; b_tag = tag;
    n = 0;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!b_in_ready) check("b_ready_timeout", 0, 1);
    else if (expout) qb.push_back({err, gid, tag});
    @(posedge clk); #1;
  endtask

  task automatic send_c(input logic [7:0] dst, input logic [7:0] src, input logic [2:0] pri,
                        input logic [15:0] tag, input bit expout, input logic [7:0] gid, input bit err);
    int n;
    c_in_valid = 1; c_dst = dst; c_src = src; c_pri = pri; c_tag = tag;
    n = 0;
    @(negedge clk);
    while (!c_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!c_in_ready) check("c_ready_timeout", 0, 1);
    else if (expout) qc.push_back({err, gid, tag});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // Reset state
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_gid",   32'(a_out_gid),   0);
    check("rst_out_err",   32'(a_out_err),   0);
    check("rst_out_tag",   32'(a_out_tag),   0);
    check("rst_drop_cnt",  32'(a_cnt),       0);
    check("rst_in_ready",  32'(a_in_ready),  1);

    // Basic mapping and 1-cycle latency
    send_a(4'b1000, 4'b0100, 2'd2, 16'hABCD, 1, 8'd10, 0);
    check("lat_out_valid", 32'(a_out_valid), 1);
    idle(2);

    // Back-to-back sweep: three consecutive beats
    send_a(4'b0001, 4'b0010, 2'd0, 16'h0001, 1, 8'd0, 0);
    check("b2b_beat0", 32'(a_out_valid), 1);
    send_a(4'b0001, 4'b0100, 2'd0, 16'h0002, 1, 8'd4, 0);
    check("b2b_beat1", 32'(a_out_valid), 1);
    send_a(4'b0001, 4'b1000, 2'd0, 16'h0003, 1, 8'd8, 0);
    check("b2b_beat2", 32'(a_out_valid), 1);
    idle(2);

    // Backpressure: second descriptor stalls while the first is held
    a_ordy = 0;
    send_a(4'b1000, 4'b0100, 2'd2, 16'h1111, 1, 8'd10, 0);
    a_in_valid = 1; a_dst = 4'b0001; a_src = 4'b0010; a_pri = 2'd3; a_tag = 16'h2222;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(a_in_ready), 0);
      check("bp_hold_gid", 32'(a_out_gid), 10);
      check("bp_hold_tag", 32'(a_out_tag), 32'h1111);
    end
    @(posedge clk); #1;
    a_ordy = 1;
    qa.push_back({1'b0, 8'd3, 16'h2222});
    @(posedge clk); #1;
    idle(3);
    check("bp_queue_drained", 32'(qa.size()), 0);

    // Drop mode: two malformed descriptors, then clear
    send_a(4'b0010, 4'b0010, 2'd1, 16'h0BAD, 0, 8'd0, 0);
    send_a(4'b0010, 4'b0011, 2'd1, 16'h0BAD, 0, 8'd0, 0);
    idle(2);
    check("drop_cnt_2", 32'(a_cnt), 2);
    a_clr = 1; @(posedge clk); #1; a_clr = 0;
    check("drop_cnt_clr", 32'(a_cnt), 0);

    // Flag mode: malformed descriptor forwarded with err
    send_b(4'b0000, 4'b0010, 2'd1, 16'h1234, 1, 8'd0, 1);
    check("flag_out_valid", 32'(b_out_valid), 1);
    check("flag_out_err",   32'(b_out_err),   1);
    check("flag_out_gid",   32'(b_out_gid),   0);
    send_b(4'b0001, 4'b1000, 2'd3, 16'h5678, 1, 8'd11, 0);
    send_b(4'b0100, 4'b0100, 2'd2, 16'h9999, 1, 8'd0, 1);
    idle(2);
    check("flag_drop_cnt", 32'(b_cnt), 0);

    // Wide build: gid and counter saturation
    send_c(8'h08, 8'h80, 3'd5, 16'hC0DE, 1, 8'd53, 0);
    send_c(8'h01, 8'h04, 3'd7, 16'hC0DF, 1, 8'd15, 0);
    send_c(8'h00, 8'h02, 3'd0, 16'h0001, 0, 8'd0, 0);
    send_c(8'h10, 8'h00, 3'd0, 16'h0002, 0, 8'd0, 0);
    send_c(8'h20, 8'h20, 3'd0, 16'h0003, 0, 8'd0, 0);
    check("sat_cnt_3", 32'(c_cnt), 3);
    send_c(8'h03, 8'h01, 3'd0, 16'h0004, 0, 8'd0, 0);
    send_c(8'h01, 8'hFF, 3'd0, 16'h0005, 0, 8'd0, 0);
    check("sat_cnt_hold", 32'(c_cnt), 3);
    c_clr = 1;
    send_c(8'h02, 8'h02, 3'd0, 16'h0006, 0, 8'd0, 0);
    c_clr = 0;
    check("clr_beats_drop", 32'(c_cnt), 0);
    idle(2);
    check("c_queue_drained", 32'(qc.size()), 0);

    // Reset mid-transfer discards the held result
    c_ordy = 0;
    send_c(8'h01, 8'h02, 3'd1, 16'hDEAD, 1, 8'd1, 0);
    c_in_valid = 0;
    check("pre_rst_valid", 32'(c_out_valid), 1);
    rst = 1; @(posedge clk); #1;
    check("mid_rst_valid", 32'(c_out_valid), 0);
    check("mid_rst_gid",   32'(c_out_gid),   0);
    rst = 0;
    qc.delete();
    c_ordy = 1;
    check("post_rst_ready", 32'(c_in_ready), 1);
    idle(2);
    check("a_queue_empty", 32'(qa.size()), 0);
    check("b_queue_empty", 32'(qb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
